// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver. It takes one bit per strobe in either shift direction
// and presents each completed word on Q with a VALID/ACK handshake and a sticky overrun flag.
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SER,
    input  logic             STB,
    input  logic             DIR,
    input  logic             SYNC,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sr_r;
    logic             ldir_r;
    logic [WIDTH-1:0] q_r;
    logic             valid_r;
    logic             busy_r;
    logic             ovf_r;

    logic             start_s;
    logic             eff_dir_s;
    logic [WIDTH-1:0] sr_base_s;
    logic [CW-1:0]    cnt_base_s;
    logic [WIDTH-1:0] shifted_s;
    logic             complete_s;

    // SYNC restarts framing, so the strobed bit shifts into an empty register as bit 1
    always_comb begin
        start_s    = SYNC || (state_r == IDLE);
        eff_dir_s  = start_s ? DIR : ldir_r;
        sr_base_s  = SYNC ? {WIDTH{1'b0}} : sr_r;
        cnt_base_s = SYNC ? {CW{1'b0}} : cnt_r;
        if (eff_dir_s) begin
            shifted_s = {sr_base_s[WIDTH-2:0], SER};
        end else begin
            shifted_s = {SER, sr_base_s[WIDTH-1:1]};
        end
        complete_s = STB && (cnt_base_s == CNT_LAST);
    end

    // Receive FSM, output register and handshake/overrun flags
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            sr_r    <= {WIDTH{1'b0}};
            ldir_r  <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (STB) begin
                sr_r   <= shifted_s;
                ldir_r <= eff_dir_s;
                if (complete_s) begin
                    cnt_r   <= {CW{1'b0}};
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end else begin
                    cnt_r   <= cnt_base_s + CNT_ONE;
                    state_r <= SHIFT;
                    busy_r  <= 1'b1;
                end
            end else if (SYNC) begin
                cnt_r   <= {CW{1'b0}};
                sr_r    <= {WIDTH{1'b0}};
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                cnt_r   <= cnt_r;
                state_r <= state_r;
            end

            // An unacknowledged word is never overwritten; the new one is dropped instead
            if (complete_s && (!valid_r || ACK)) begin
                q_r     <= shifted_s;
                valid_r <= 1'b1;
            end else if (complete_s) begin
                ovf_r   <= 1'b1;
            end else if (valid_r && ACK) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign Q     = q_r;
    assign VALID = valid_r;
    assign BUSY  = busy_r;
    assign OVF   = ovf_r;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed self-checking bench for serial_word_rx with WIDTH=4.
module tb_serial_word_rx;

    logic       CLK;
    logic       CLR;
    logic       SER;
    logic       STB;
    logic       DIR;
    logic       SYNC;
    logic       ACK;
    logic [3:0] Q;
    logic       VALID;
    logic       BUSY;
    logic       OVF;

    int checks_r;
    int errors_r;

    serial_word_rx #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .SER   (SER),
        .STB   (STB),
        .DIR   (DIR),
        .SYNC  (SYNC),
        .ACK   (ACK),
        .Q     (Q),
        .VALID (VALID),
        .BUSY  (BUSY),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs are settled 1 time unit after the edge.
    task automatic step(input logic stb, input logic ser, input logic dir,
                        input logic sync, input logic ack, input logic clr);
        STB  = stb;
        SER  = ser;
        DIR  = dir;
        SYNC = sync;
        ACK  = ack;
        CLR  = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends b[3] first; ACK is raised only alongside the final bit when ack_last is set.
    task automatic word(input logic [3:0] b, input logic dir, input logic ack_last, input int gap);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, b[i], dir, 1'b0, (i == 0) ? ack_last : 1'b0, 1'b0);
            if (i != 0) idle(gap);
        end
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        STB = 1'b0; SER = 1'b0; DIR = 1'b0; SYNC = 1'b0; ACK = 1'b0; CLR = 1'b0;

        // Reset values
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_ovf", 32'(OVF), 32'h0);

        // DIR=1, consecutive strobes 1,0,1,1 -> 1011
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_b1", 32'(BUSY), 32'h1);
        chk("t1_valid_b1", 32'(VALID), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_b2", 32'(BUSY), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_b3", 32'(BUSY), 32'h1);
        chk("t1_valid_b3", 32'(VALID), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_q", 32'(Q), 32'hB);
        chk("t1_valid", 32'(VALID), 32'h1);
        chk("t1_busy_done", 32'(BUSY), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_ack_valid", 32'(VALID), 32'h0);
        chk("t1_ack_q", 32'(Q), 32'hB);

        // DIR=0 with 2-cycle gaps, DIR toggled after bit 1 -> 1101
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("t2_busy_gap", 32'(BUSY), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_q", 32'(Q), 32'hD);
        chk("t2_valid", 32'(VALID), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: 1011 left unacknowledged, then 0001
        word(4'b1011, 1'b1, 1'b0, 0);
        chk("t3_q1", 32'(Q), 32'hB);
        word(4'b0001, 1'b1, 1'b0, 0);
        chk("t3_q_held", 32'(Q), 32'hB);
        chk("t3_valid", 32'(VALID), 32'h1);
        chk("t3_ovf", 32'(OVF), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_ack_valid", 32'(VALID), 32'h0);
        chk("t3_ovf_sticky", 32'(OVF), 32'h1);
        idle(3);
        chk("t3_ovf_sticky2", 32'(OVF), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr_ovf", 32'(OVF), 32'h0);

        // ACK coincident with completion of 0110 reloads Q, no overrun
        word(4'b1011, 1'b1, 1'b0, 0);
        word(4'b0110, 1'b1, 1'b1, 0);
        chk("t4_q", 32'(Q), 32'h6);
        chk("t4_valid", 32'(VALID), 32'h1);
        chk("t4_ovf", 32'(OVF), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_ack_valid", 32'(VALID), 32'h0);

        // Two bits, SYNC with STB (SER=1), then 1,0,0 -> 1100
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_busy_sync", 32'(BUSY), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_valid_pre", 32'(VALID), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_q", 32'(Q), 32'hC);
        chk("t5_valid", 32'(VALID), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // CLR after three bits, then a fresh DIR=0 word 1,1,0,0 -> 0011
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_clr_q", 32'(Q), 32'h0);
        chk("t6_clr_valid", 32'(VALID), 32'h0);
        chk("t6_clr_busy", 32'(BUSY), 32'h0);
        chk("t6_clr_ovf", 32'(OVF), 32'h0);
        word(4'b1100, 1'b0, 1'b0, 0);
        chk("t6_q", 32'(Q), 32'h3);
        chk("t6_valid", 32'(VALID), 32'h1);
        chk("t6_busy", 32'(BUSY), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
